// File: rtl/mux_rr_nw_pkg.sv
// Shared definitions for the registered N:1 valid/ready selector and its sub-blocks.
package mux_rr_nw_pkg;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR     = 1;

    // Select/Grant width: clog2 of the channel count, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_1_w.sv
// Combinational CHANNELS:1 WIDTH-bit mux; out-of-range selects yield zero.
module mux_n_1_w #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [WIDTH-1:0]          data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_i == SEL_W'(i)) begin
                data_o = data_i[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_rr_nw.sv
// Registered N-channel selector with valid/ready on every port; chooses by Select
// (MODE_SELECT) or by a fair round-robin search starting at ptr_q (MODE_RR).
module mux_rr_nw
    import mux_rr_nw_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int MODE     = 1,
    localparam int SEL_W   = sel_width(CHANNELS)
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [CHANNELS*WIDTH-1:0] In_Data,
    input  logic [CHANNELS-1:0]       In_Valid,
    output logic [CHANNELS-1:0]       In_Ready,
    input  logic [SEL_W-1:0]          Select,
    output logic [WIDTH-1:0]          Out_Data,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic [SEL_W-1:0]          Grant
);

    logic [WIDTH-1:0] data_q;
    logic             vld_q;
    logic [SEL_W-1:0] grant_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    logic             load;
    logic [SEL_W-1:0] chosen;
    logic             chosen_ok;
    logic [WIDTH-1:0] mux_data;

    assign load = !vld_q || Out_Ready;

    // chosen_ok already folds in the chosen channel's valid, so a transfer is load && chosen_ok.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        chosen    = '0;
        chosen_ok = 1'b0;
        idx       = 0;
        idx_s     = '0;
        if (MODE == MODE_SELECT) begin
            chosen = Select;
            for (int i = 0; i < CHANNELS; i++) begin
                if (Select == SEL_W'(i) && In_Valid[i]) begin
                    chosen_ok = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                idx_s = SEL_W'(idx);
                if (!chosen_ok && In_Valid[idx_s]) begin
                    chosen    = idx_s;
                    chosen_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            In_Ready[i] = load && chosen_ok && (chosen == SEL_W'(i));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (MODE == MODE_RR && load && chosen_ok) begin
            ptr_d = (chosen == SEL_W'(CHANNELS - 1)) ? '0 : chosen + 1'b1;
        end
    end

    mux_n_1_w #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .data_i (In_Data),
        .sel_i  (chosen),
        .data_o (mux_data)
    );

    // Output stage: data and grant only move on a transfer, valid follows every load.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else if (load) begin
            vld_q <= chosen_ok;
            ptr_q <= ptr_d;
            if (chosen_ok) begin
                data_q  <= mux_data;
                grant_q <= chosen;
            end
        end
    end

    assign Out_Data  = data_q;
    assign Out_Valid = vld_q;
    assign Grant     = grant_q;

endmodule

// File: tb/tb_mux_rr_nw.sv
// Bench for mux_rr_nw: three instances (RR x4, SELECT x4, RR x3) against a transaction-level model.
module tb_mux_rr_nw;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] a_data;  logic [3:0] a_vld, a_rdy; logic [1:0] a_sel, a_grant;
    logic [4:0]  a_out;   logic a_ov, a_ordy;
    logic [19:0] b_data;  logic [3:0] b_vld, b_rdy; logic [1:0] b_sel, b_grant;
    logic [4:0]  b_out;   logic b_ov, b_ordy;
    logic [14:0] c_data;  logic [2:0] c_vld, c_rdy; logic [1:0] c_sel, c_grant;
    logic [4:0]  c_out;   logic c_ov, c_ordy;

    mux_rr_nw #(.WIDTH(5), .CHANNELS(4), .MODE(1)) u_rr4 (
        .Clock(clk), .Reset_n(rst_n), .In_Data(a_data), .In_Valid(a_vld), .In_Ready(a_rdy),
        .Select(a_sel), .Out_Data(a_out), .Out_Valid(a_ov), .Out_Ready(a_ordy), .Grant(a_grant));
    mux_rr_nw #(.WIDTH(5), .CHANNELS(4), .MODE(0)) u_sel4 (
        .Clock(clk), .Reset_n(rst_n), .In_Data(b_data), .In_Valid(b_vld), .In_Ready(b_rdy),
        .Select(b_sel), .Out_Data(b_out), .Out_Valid(b_ov), .Out_Ready(b_ordy), .Grant(b_grant));
    mux_rr_nw #(.WIDTH(5), .CHANNELS(3), .MODE(1)) u_rr3 (
        .Clock(clk), .Reset_n(rst_n), .In_Data(c_data), .In_Valid(c_vld), .In_Ready(c_rdy),
        .Select(c_sel), .Out_Data(c_out), .Out_Valid(c_ov), .Out_Ready(c_ordy), .Grant(c_grant));

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, the word held at the output and the round-robin start.
    int NCH[3] = '{4, 4, 3};
    int MD[3]  = '{1, 0, 1};
    int m_vld[3], m_data[3], m_grant[3], m_ptr[3];
    logic [3:0]  in_v[3];
    logic [19:0] in_d[3];
    int          in_sel[3];
    logic        in_ordy[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel the spec's rules pick, or -1 when nothing can be taken.
    function automatic int pick(input int n, input int mode, input logic [3:0] v,
                                input int sel, input int ptr);
        if (mode == 0) return (sel < n && v[sel]) ? sel : -1;
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic drive(input int d, input logic [3:0] v, input logic [19:0] data,
                         input int sel, input logic ordy);
        in_v[d] = v; in_d[d] = data; in_sel[d] = sel; in_ordy[d] = ordy;
        case (d)
            0: begin a_vld = v; a_data = data; a_sel = 2'(sel); a_ordy = ordy; end
            1: begin b_vld = v; b_data = data; b_sel = 2'(sel); b_ordy = ordy; end
            default: begin c_vld = v[2:0]; c_data = data[14:0]; c_sel = 2'(sel); c_ordy = ordy; end
        endcase
    endtask

    task automatic check_out(input int d, input string tag);
        logic ov; logic [4:0] od; logic [1:0] og;
        case (d)
            0: begin ov = a_ov; od = a_out; og = a_grant; end
            1: begin ov = b_ov; od = b_out; og = b_grant; end
            default: begin ov = c_ov; od = c_out; og = c_grant; end
        endcase
        check({tag, "_valid"}, 32'(ov), 32'(m_vld[d]));
        check({tag, "_data"},  32'(od), 32'(m_data[d]));
        check({tag, "_grant"}, 32'(og), 32'(m_grant[d]));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_vld[d] = 0; m_data[d] = 0; m_grant[d] = 0; m_ptr[d] = 0;
        end
    endtask

    // One clock on instance d with the inputs already driven.
    task automatic step(input int d, input string tag);
        int n, c; logic ld; logic [3:0] v, exp_rdy, act_rdy;
        #1;
        n  = NCH[d];
        v  = in_v[d] & 4'((1 << n) - 1);
        ld = (m_vld[d] == 0) || in_ordy[d];
        c  = pick(n, MD[d], v, in_sel[d], m_ptr[d]);
        exp_rdy = (ld && c >= 0) ? 4'(1 << c) : 4'd0;
        case (d)
            0: act_rdy = a_rdy;
            1: act_rdy = b_rdy;
            default: act_rdy = {1'b0, c_rdy};
        endcase
        check({tag, "_rdy"}, 32'(act_rdy), 32'(exp_rdy));
        if (ld) begin
            if (c >= 0) begin
                m_vld[d] = 1;
                m_data[d] = int'((in_d[d] >> (5 * c)) & 20'h1F);
                m_grant[d] = c;
                if (MD[d] == 1) m_ptr[d] = (c + 1) % n;
            end else begin
                m_vld[d] = 0;
            end
        end
        @(posedge clk); #1;
        check_out(d, tag);
    endtask

    initial begin
        model_reset();
        for (int d = 0; d < 3; d++) drive(d, 4'd0, 20'd0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check_out(d, "init_reset");
        rst_n = 1'b1;

        // Round-robin over four always-valid channels.
        for (int k = 0; k < 8; k++) begin
            drive(0, 4'b1111, 20'($urandom), 0, 1'b1);
            step(0, "rr4_all");
            check("rr4_all_seq", 32'(a_grant), 32'(k % 4));
        end

        // Only channels 1 and 3 request.
        for (int k = 0; k < 6; k++) begin
            drive(0, 4'b1010, 20'($urandom), 0, 1'b1);
            step(0, "rr4_1010");
            check("rr4_1010_seq", 32'(a_grant), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Back-pressure holding 5'h15, then release loads on the same edge.
        drive(0, 4'b1111, {4{5'h15}}, 0, 1'b1);
        step(0, "bp_load");
        for (int k = 0; k < 3; k++) begin
            drive(0, 4'b1111, 20'($urandom), 0, 1'b0);
            step(0, "bp_stall");
            check("bp_hold", 32'(a_out), 32'h15);
        end
        drive(0, 4'b1111, 20'($urandom), 0, 1'b1);
        step(0, "bp_release");

        for (int k = 0; k < 40; k++) begin
            drive(0, 4'($urandom), 20'($urandom), 0, 1'($urandom_range(0, 1)));
            step(0, "rr4_rand");
        end

        // Externally selected mode.
        drive(1, 4'b0100, {5'h03, 5'h1F, 5'h0A, 5'h05}, 2, 1'b1);
        step(1, "sel_ch2");
        check("sel_ch2_data", 32'(b_out), 32'h1F);
        drive(1, 4'b0111, 20'($urandom), 3, 1'b1);
        step(1, "sel_ch3_idle");
        check("sel_ch3_drop", 32'(b_ov), 32'd0);
        for (int k = 0; k < 40; k++) begin
            drive(1, 4'($urandom), 20'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            step(1, "sel_rand");
        end

        // Three channels: pointer wraps after 2.
        for (int k = 0; k < 6; k++) begin
            drive(2, 4'b0111, 20'($urandom), 3, 1'b1);
            step(2, "rr3_all");
            check("rr3_seq", 32'(c_grant), 32'(k % 3));
        end
        for (int k = 0; k < 30; k++) begin
            drive(2, 4'($urandom), 20'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            step(2, "rr3_rand");
        end

        // Asynchronous reset with a word in flight.
        drive(0, 4'b1111, 20'($urandom), 0, 1'b1);
        step(0, "pre_reset");
        check("pre_reset_vld", 32'(a_ov), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) check_out(d, "async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 4'b1111, 20'($urandom), 0, 1'b1);
        step(0, "post_reset");
        check("post_reset_ch0", 32'(a_grant), 32'd0);
        drive(0, 4'b1111, 20'($urandom), 0, 1'b1);
        step(0, "post_reset2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
